// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that decodes 24-bit frames into
// register-table writes, or returns register read data on MISO.
module spi_reg_bridge #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 16,
    parameter int SCLK_MIN_DIV = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr,
    output logic [DATA_WIDTH-1:0] reg_din,
    output logic [ADDR_WIDTH-1:0] reg_addr_r,
    input  logic [DATA_WIDTH-1:0] reg_dout,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CMD_BITS   = 1 + ADDR_WIDTH;
    localparam int FRAME_BITS = CMD_BITS + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BITS);

    // Read data must be loaded before the first data-phase SCLK fall.
    if (SCLK_MIN_DIV < 6) begin : g_div_check
        $error("SCLK_MIN_DIV too small for read turnaround");
    end

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        COMMIT,
        WAIT_CS
    } state_t;

    state_t                state_q;
    logic [2:0]            sclk_q;
    logic [2:0]            cs_q;
    logic [1:0]            mosi_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic                  rw_q;
    logic                  load_q;
    logic                  spi_miso_q;
    logic [ADDR_WIDTH-1:0] reg_addr_q;
    logic [DATA_WIDTH-1:0] reg_din_q;
    logic [ADDR_WIDTH-1:0] reg_addr_r_q;
    logic                  reg_wr_q;
    logic                  frame_done_q;
    logic                  frame_err_q;

    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  cs_rise;
    logic                  cs_fall;
    logic                  mosi_s;
    logic [DATA_WIDTH-1:0] rx_next;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign mosi_s    = mosi_q[1];
    assign rx_next   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    // Sync flops reset low so a cs_n already low at release is no edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sclk_q       <= '0;
            cs_q         <= '0;
            mosi_q       <= '0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            rw_q         <= 1'b0;
            load_q       <= 1'b0;
            spi_miso_q   <= 1'b0;
            reg_addr_q   <= '0;
            reg_din_q    <= '0;
            reg_addr_r_q <= '0;
            reg_wr_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_q       <= {sclk_q[1:0], spi_sclk};
            cs_q         <= {cs_q[1:0], spi_cs_n};
            mosi_q       <= {mosi_q[0], spi_mosi};
            reg_wr_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            load_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    spi_miso_q <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt_q <= '0;
                        state_q   <= CMD;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (bit_cnt_q == CMD_END) begin
                        rw_q         <= rx_shift_q[ADDR_WIDTH];
                        reg_addr_r_q <= rx_shift_q[ADDR_WIDTH-1:0];
                        load_q       <= 1'b1;
                        state_q      <= DATA;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_next;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        spi_miso_q  <= 1'b0;
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (bit_cnt_q == FRAME_END) begin
                        spi_miso_q   <= 1'b0;
                        reg_wr_q     <= rw_q;
                        frame_done_q <= 1'b1;
                        state_q      <= COMMIT;
                        if (rw_q) begin
                            reg_addr_q <= reg_addr_r_q;
                            reg_din_q  <= rx_shift_q;
                        end
                    end else begin
                        if (load_q) begin
                            tx_shift_q <= rw_q ? '0 : reg_dout;
                        end else if (sclk_fall) begin
                            spi_miso_q <= tx_shift_q[DATA_WIDTH-1];
                            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_shift_q <= rx_next;
                            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state_q <= cs_rise ? IDLE : WAIT_CS;
                end
                WAIT_CS: begin
                    spi_miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_miso   = spi_miso_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wr     = reg_wr_q;
    assign reg_din    = reg_din_q;
    assign reg_addr_r = reg_addr_r_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed SPI frames against a static register
// table, plus reset, abort and back-to-back sequences.
module tb_spi_reg_bridge;

    localparam int AW = 7;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic          spi_mosi;
    logic          spi_miso;
    logic [AW-1:0] reg_addr;
    logic          reg_wr;
    logic [DW-1:0] reg_din;
    logic [AW-1:0] reg_addr_r;
    logic [DW-1:0] reg_dout;
    logic          frame_done;
    logic          frame_err;

    logic [DW-1:0] mem [0:127];

    spi_reg_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SCLK_MIN_DIV(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .reg_addr(reg_addr),
        .reg_wr(reg_wr),
        .reg_din(reg_din),
        .reg_addr_r(reg_addr_r),
        .reg_dout(reg_dout),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign reg_dout = mem[reg_addr_r];

    int            total = 0;
    int            bad = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    time           t_wr = 0;
    bit            long_pulse = 1'b0;
    logic          wr_prev = 1'b0;
    logic          done_prev = 1'b0;
    logic          err_prev = 1'b0;
    logic [AW-1:0] wa_log[$];
    logic [DW-1:0] wd_log[$];

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            t_wr = $time;
            wa_log.push_back(reg_addr);
            wd_log.push_back(reg_din);
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if ((reg_wr && wr_prev) || (frame_done && done_prev) ||
            (frame_err && err_prev))
            long_pulse = 1'b1;
        wr_prev   = reg_wr;
        done_prev = frame_done;
        err_prev  = frame_err;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCLK = clk/8; MISO sampled just before each rising SCLK edge.
    task automatic run_frame(input logic [23:0] w, input int nbits,
                             input int hi_cyc, input int rst_at,
                             output logic [23:0] cap, output time t24,
                             output logic [33:0] snap);
        cap  = '0;
        t24  = 0;
        snap = '1;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                snap = {reg_addr, reg_din, reg_addr_r, spi_miso,
                        reg_wr, frame_done, frame_err};
                rst = 1'b1;
            end
            spi_mosi = (i < 24) ? w[23-i] : 1'b1;
            wait_n(4);
            cap = {cap[22:0], spi_miso};
            spi_sclk = 1'b1;
            if (i == 23) t24 = $time;
            wait_n(4);
            spi_sclk = 1'b0;
        end
        wait_n(2);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_n(hi_cyc);
    endtask

    typedef struct {
        logic [23:0]   frame;
        int            nbits;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
        logic          exp_done;
        logic          exp_err;
        logic          chk_miso;
        logic [DW-1:0] exp_miso;
        logic [AW-1:0] exp_addr_r;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] cap;
        time         t24;
        logic [33:0] snap;
        int          w0, d0, e0, n;

        for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
        mem[7'h30] = 16'hA55A;

        vt[0]  = '{24'h820003, 24, 1'b1, 7'h02, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0000, 7'h02};
        vt[1]  = '{24'h300000, 24, 1'b0, 7'h02, 16'h0003, 1'b1, 1'b0, 1'b1, 16'hA55A, 7'h30};
        vt[2]  = '{24'h8ABEEF, 12, 1'b0, 7'h02, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0000, 7'h0A};
        vt[3]  = '{24'h800000, 24, 1'b1, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 7'h00};
        vt[4]  = '{24'h851111, 24, 1'b1, 7'h05, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h0000, 7'h05};
        vt[5]  = '{24'h901234, 32, 1'b1, 7'h10, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 7'h10};
        vt[6]  = '{24'h7F0000, 24, 1'b0, 7'h10, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h107F, 7'h7F};
        vt[7]  = '{24'hFFFFFF, 24, 1'b1, 7'h7F, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 7'h7F};
        vt[8]  = '{24'h300000, 20, 1'b0, 7'h7F, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 7'h30};
        vt[9]  = '{24'h81ABCD,  8, 1'b0, 7'h7F, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 7'h01};
        vt[10] = '{24'h8F0000,  0, 1'b0, 7'h7F, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 7'h01};

        rst      = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        wait_n(3);
        chk("rst_miso", spi_miso, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wr", reg_wr, 0);
        chk("rst_din", reg_din, 0);
        chk("rst_addr_r", reg_addr_r, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        rst = 1'b1;
        wait_n(6);

        for (int k = 0; k < NV; k++) begin
            w0 = wr_cnt;
            d0 = done_cnt;
            e0 = err_cnt;
            run_frame(vt[k].frame, vt[k].nbits, 8, -1, cap, t24, snap);
            chk($sformatf("v%0d_wr", k), 64'(wr_cnt - w0), 64'(vt[k].exp_wr));
            chk($sformatf("v%0d_done", k), 64'(done_cnt - d0), 64'(vt[k].exp_done));
            chk($sformatf("v%0d_err", k), 64'(err_cnt - e0), 64'(vt[k].exp_err));
            chk($sformatf("v%0d_addr", k), reg_addr, vt[k].exp_addr);
            chk($sformatf("v%0d_din", k), reg_din, vt[k].exp_din);
            chk($sformatf("v%0d_addr_r", k), reg_addr_r, vt[k].exp_addr_r);
            chk($sformatf("v%0d_miso_idle", k), spi_miso, 0);
            if (vt[k].exp_wr)
                chk($sformatf("v%0d_wr_latency", k), t_wr - t24, 64'd40);
            if (vt[k].chk_miso)
                chk($sformatf("v%0d_miso_bits", k), cap, {8'h00, vt[k].exp_miso});
        end

        // Reset pulse at bit 20 of a write; cs_n stays low afterwards.
        w0 = wr_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(24'h825555, 24, 8, 19, cap, t24, snap);
        chk("rst_mid_outputs", snap, 0);
        chk("rst_mid_wr", 64'(wr_cnt - w0), 0);
        chk("rst_mid_done", 64'(done_cnt - d0), 0);
        chk("rst_mid_err", 64'(err_cnt - e0), 0);
        chk("rst_mid_addr", reg_addr, 0);
        chk("rst_mid_din", reg_din, 0);

        // cs_n held low across reset release: whole frame ignored.
        rst      = 1'b0;
        spi_cs_n = 1'b0;
        wait_n(3);
        rst = 1'b1;
        wait_n(3);
        w0 = wr_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(24'h8CAAAA, 24, 8, -1, cap, t24, snap);
        chk("cs_low_rst_wr", 64'(wr_cnt - w0), 0);
        chk("cs_low_rst_done", 64'(done_cnt - d0), 0);
        chk("cs_low_rst_err", 64'(err_cnt - e0), 0);
        chk("cs_low_rst_addr_r", reg_addr_r, 0);
        w0 = wr_cnt;
        run_frame(24'h8CAAAA, 24, 8, -1, cap, t24, snap);
        chk("after_toggle_wr", 64'(wr_cnt - w0), 1);
        chk("after_toggle_addr", reg_addr, 7'h0C);
        chk("after_toggle_din", reg_din, 16'hAAAA);

        // Back-to-back writes, cs_n high for only 4 clk cycles between.
        w0 = wr_cnt;
        d0 = done_cnt;
        run_frame(24'h8100FF, 24, 4, -1, cap, t24, snap);
        run_frame(24'h8303FF, 24, 8, -1, cap, t24, snap);
        chk("b2b_wr", 64'(wr_cnt - w0), 2);
        chk("b2b_done", 64'(done_cnt - d0), 2);
        n = wa_log.size();
        if (n >= 2) begin
            chk("b2b_addr0", wa_log[n-2], 7'h01);
            chk("b2b_din0", wd_log[n-2], 16'h00FF);
            chk("b2b_addr1", wa_log[n-1], 7'h03);
            chk("b2b_din1", wd_log[n-1], 16'h03FF);
        end else begin
            chk("b2b_log_size", 64'(n), 2);
        end

        chk("pulse_width", long_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
